topk_sort_ctrl: RTL and testbench

- Window-based controller that keeps the K highest-intensity echo candidates, as (intensity, distance) pairs, from a streamed measurement window.
- At end of window, emits the retained entries in descending intensity order over a valid/ready output.
- Sits between the echo-candidate front end and the per-channel result packer, and replaces free-running replacement of the minimum entry with a sequenced collect/emit protocol.

---
 rtl/topk_sort_ctrl_pkg.sv | 29 ++
 rtl/topk_sort_ctrl_argsel.sv | 33 +++
 rtl/topk_sort_ctrl.sv | 240 ++++++++++++++++++++++++
 tb/tb_topk_sort_ctrl.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/topk_sort_ctrl_pkg.sv
// Shared types and defaults for the top-K echo candidate controller.
package topk_sort_ctrl_pkg;

   localparam int TOPK_K      = 3;
   localparam int TOPK_INT_W  = 5;
   localparam int TOPK_DATA_W = 10;
   localparam int RANK_W      = 3;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_COLLECT  = 2'd1,
      ST_EMIT_SEL = 2'd2,
      ST_EMIT_OUT = 2'd3
   } state_t;

   // One retained candidate at the default widths.
   typedef struct packed {
      logic                   valid;
      logic                   emitted;
      logic [TOPK_INT_W-1:0]  intensity;
      logic [TOPK_DATA_W-1:0] data;
   } entry_t;

   // Index width for an n-entry table; a single entry still needs one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/topk_sort_ctrl_argsel.sv
// Combinational arg-min / arg-max over K keyed entries. Strict comparison
// means an equal key never displaces an earlier one, so ties keep the lowest index.
module topk_argsel
   import topk_sort_ctrl_pkg::*;
#(
   parameter int K     = TOPK_K,
   parameter int KEY_W = TOPK_INT_W + 1,
   parameter int IW    = idx_w(TOPK_K)
) (
   input  logic             mode_max,
   input  logic [K-1:0]     elig,
   input  logic [KEY_W-1:0] key [K],
   output logic [IW-1:0]    idx
);

   logic [KEY_W-1:0] best;
   logic             found;

   // Linear scan keeping the best eligible key seen so far.
   always_comb begin
      best  = '0;
      found = 1'b0;
      idx   = '0;
      for (int i = 0; i < K; i++) begin
         if (elig[i] && (!found || (mode_max ? (key[i] > best) : (key[i] < best)))) begin
            best  = key[i];
            found = 1'b1;
            idx   = IW'(i);
         end
      end
   end

endmodule

// File: rtl/topk_sort_ctrl.sv
// Keeps the K strongest echo candidates of a measurement window and emits
// them strongest-first over a valid/ready port once the window closes.
//
//   state       | meaning
//   ------------+-----------------------------------------------------------
//   IDLE        | waiting for start; outputs quiet
//   COLLECT     | accepting candidates, filling/replacing the retained set
//   EMIT_SEL    | picking the strongest unemitted entry, loading the payload
//   EMIT_OUT    | holding out_valid until the result is taken
module topk_sort_ctrl
   import topk_sort_ctrl_pkg::*;
#(
   parameter int K      = TOPK_K,
   parameter int INT_W  = TOPK_INT_W,
   parameter int DATA_W = TOPK_DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [INT_W-1:0]  in_int,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [INT_W-1:0]  out_int,
   output logic [DATA_W-1:0] out_data,
   output logic [RANK_W-1:0] out_rank,
   output logic              out_last,
   output logic              busy
);

   localparam int IW    = idx_w(K);
   localparam int KEY_W = INT_W + 1;

   state_t state_q, state_d;

   logic [K-1:0]      ent_valid_q;
   logic [K-1:0]      ent_emitted_q;
   logic [INT_W-1:0]  ent_int_q  [K];
   logic [DATA_W-1:0] ent_data_q [K];

   logic [IW-1:0]     min_idx_q;
   logic [INT_W-1:0]  min_int_q;
   logic              wrote_q;
   logic [IW-1:0]     sel_idx_q;
   logic [RANK_W-1:0] rank_q;

   logic              sel_mode;
   logic [K-1:0]      elig;
   logic [KEY_W-1:0]  key [K];
   logic [IW-1:0]     as_idx;
   logic [K-1:0]      as_oh;
   logic              has_free;
   logic [IW-1:0]     first_free;

   logic              wr_en;
   logic [IW-1:0]     wr_idx;
   logic              clr_entries;
   logic              do_sel;
   logic              do_hs;
   logic              go_idle;

   // One selector serves both jobs: max over unemitted entries in EMIT_SEL,
   // min over the whole table otherwise. In min mode the valid bit is the key
   // MSB so any invalid slot reads as the smallest.
   always_comb begin
      sel_mode = (state_q == ST_EMIT_SEL);
      elig     = sel_mode ? (ent_valid_q & ~ent_emitted_q) : {K{1'b1}};
      for (int i = 0; i < K; i++) begin
         if (sel_mode)
            key[i] = {1'b0, ent_int_q[i]};
         else
            key[i] = ent_valid_q[i] ? {1'b1, ent_int_q[i]} : '0;
      end
   end

   topk_argsel #(
      .K     (K),
      .KEY_W (KEY_W),
      .IW    (IW)
   ) u_argsel (
      .mode_max (sel_mode),
      .elig     (elig),
      .key      (key),
      .idx      (as_idx)
   );

   // One-hot of the selected index, used to see whether anything else remains.
   always_comb begin
      for (int i = 0; i < K; i++)
         as_oh[i] = (as_idx == IW'(i));
   end

   // Lowest-index free slot; scanning downward lets the lowest index win.
   always_comb begin
      has_free   = 1'b0;
      first_free = '0;
      for (int i = K - 1; i >= 0; i--) begin
         if (!ent_valid_q[i]) begin
            has_free   = 1'b1;
            first_free = IW'(i);
         end
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

   // Next state, handshake outputs and datapath strobes; abort overrides everything.
   always_comb begin
      state_d     = state_q;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      busy        = (state_q != ST_IDLE);
      wr_en       = 1'b0;
      wr_idx      = first_free;
      clr_entries = 1'b0;
      do_sel      = 1'b0;
      do_hs       = 1'b0;
      go_idle     = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d     = ST_COLLECT;
               clr_entries = 1'b1;
            end
         end
         ST_COLLECT: begin
            // The cycle after a write the min tracker is stale, hence the bubble.
            in_ready = !wrote_q;
            if (in_valid && !wrote_q) begin
               if (has_free) begin
                  wr_en = 1'b1;
               end else if (in_int > min_int_q) begin
                  wr_en  = 1'b1;
                  wr_idx = min_idx_q;
               end
               if (in_last)
                  state_d = ST_EMIT_SEL;
            end
         end
         ST_EMIT_SEL: begin
            do_sel  = 1'b1;
            state_d = ST_EMIT_OUT;
         end
         ST_EMIT_OUT: begin
            out_valid = 1'b1;
            if (out_ready) begin
               do_hs = 1'b1;
               if (out_last) begin
                  state_d = ST_IDLE;
                  go_idle = 1'b1;
               end else begin
                  state_d = ST_EMIT_SEL;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (abort) begin
         state_d     = ST_IDLE;
         clr_entries = 1'b1;
         go_idle     = 1'b1;
         wr_en       = 1'b0;
         do_sel      = 1'b0;
         do_hs       = 1'b0;
      end
   end

   // Entry table, min tracker and emit bookkeeping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ent_valid_q   <= '0;
         ent_emitted_q <= '0;
         for (int i = 0; i < K; i++) begin
            ent_int_q[i]  <= '0;
            ent_data_q[i] <= '0;
         end
         min_idx_q <= '0;
         min_int_q <= '0;
         wrote_q   <= 1'b0;
         sel_idx_q <= '0;
         rank_q    <= '0;
      end else begin
         wrote_q <= wr_en;
         if (!sel_mode) begin
            min_idx_q <= as_idx;
            min_int_q <= ent_valid_q[as_idx] ? ent_int_q[as_idx] : '0;
         end
         if (clr_entries) begin
            ent_valid_q   <= '0;
            ent_emitted_q <= '0;
            rank_q        <= '0;
         end
         if (wr_en) begin
            ent_valid_q[wr_idx]   <= 1'b1;
            ent_emitted_q[wr_idx] <= 1'b0;
            ent_int_q[wr_idx]     <= in_int;
            ent_data_q[wr_idx]    <= in_data;
         end
         if (do_sel)
            sel_idx_q <= as_idx;
         if (do_hs) begin
            ent_emitted_q[sel_idx_q] <= 1'b1;
            rank_q                   <= rank_q + RANK_W'(1);
         end
      end
   end

   // Result payload: loaded in EMIT_SEL, held through EMIT_OUT, zeroed on return to IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_int  <= '0;
         out_data <= '0;
         out_rank <= '0;
         out_last <= 1'b0;
      end else if (go_idle) begin
         out_int  <= '0;
         out_data <= '0;
         out_rank <= '0;
         out_last <= 1'b0;
      end else if (do_sel) begin
         out_int  <= ent_int_q[as_idx];
         out_data <= ent_data_q[as_idx];
         out_rank <= rank_q;
         out_last <= ((elig & ~as_oh) == '0);
      end
   end

endmodule

// File: tb/tb_topk_sort_ctrl.sv
// Bench for topk_sort_ctrl: a window-level reference model checked every
// cycle, directed windows pinned to hand-worked results, then random windows.
module tb_topk_sort_ctrl;
   import topk_sort_ctrl_pkg::*;

   localparam int K      = 3;
   localparam int INT_W  = 5;
   localparam int DATA_W = 10;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic              abort = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [INT_W-1:0]  in_int = '0;
   logic [DATA_W-1:0] in_data = '0;
   logic              in_last = 1'b0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [INT_W-1:0]  out_int;
   logic [DATA_W-1:0] out_data;
   logic [2:0]        out_rank;
   logic              out_last;
   logic              busy;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   topk_sort_ctrl #(.K(K), .INT_W(INT_W), .DATA_W(DATA_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .abort     (abort),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_int    (in_int),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_int   (out_int),
      .out_data  (out_data),
      .out_rank  (out_rank),
      .out_last  (out_last),
      .busy      (busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic logic [31:0] pk(input int i, input int d, input int r, input int l);
      return 32'((i << 14) | (d << 4) | (r << 1) | l);
   endfunction

   // ---------------- reference model (window level) ----------------
   typedef enum {M_IDLE, M_COLLECT, M_EMIT} mph_t;
   mph_t        m_ph = M_IDLE;
   bit          m_bubble = 0;
   bit          m_gap = 0;
   int          m_rank = 0;
   int          m_cnt = 0;
   int          m_int [8];
   int          m_data [8];
   entry_t      exp_q [$];
   logic [31:0] got_q [$];
   bit          ir_log [$];
   bit          ir_log_en = 0;

   // Keep the K strongest: fill in arrival order, then replace the weakest
   // (earliest on ties) only if the newcomer is strictly stronger.
   function automatic bit model_insert(input int vi, input int vd);
      int mi;
      if (m_cnt < K) begin
         m_int[m_cnt]  = vi;
         m_data[m_cnt] = vd;
         m_cnt++;
         return 1'b1;
      end
      mi = 0;
      for (int i = 1; i < K; i++)
         if (m_int[i] < m_int[mi]) mi = i;
      if (vi > m_int[mi]) begin
         m_int[mi]  = vi;
         m_data[mi] = vd;
         return 1'b1;
      end
      return 1'b0;
   endfunction

   // Expected emit order: stable descending sort by intensity (slot order on ties).
   function automatic void model_build();
      entry_t e;
      int     pos;
      exp_q.delete();
      for (int i = 0; i < m_cnt; i++) begin
         e.valid     = 1'b1;
         e.emitted   = 1'b0;
         e.intensity = INT_W'(m_int[i]);
         e.data      = DATA_W'(m_data[i]);
         pos = exp_q.size();
         for (int j = 0; j < exp_q.size(); j++)
            if (exp_q[j].intensity < e.intensity) begin pos = j; break; end
         exp_q.insert(pos, e);
      end
   endfunction

   // Compare process: check every cycle, then advance the model over the coming edge.
   always @(negedge clk) begin
      bit e_ir, e_ov, wrote;
      if (!rst_n) begin
         m_ph = M_IDLE; m_cnt = 0; m_bubble = 0; m_gap = 0; m_rank = 0;
         exp_q.delete();
      end else begin
         e_ir = (m_ph == M_COLLECT) && !m_bubble;
         e_ov = (m_ph == M_EMIT) && !m_gap;
         chk("busy", busy, m_ph != M_IDLE);
         chk("in_ready", in_ready, e_ir);
         chk("out_valid", out_valid, e_ov);
         if (ir_log_en) ir_log.push_back(in_ready);
         if (e_ov && out_valid && exp_q.size() > 0) begin
            chk("out_int", out_int, exp_q[0].intensity);
            chk("out_data", out_data, exp_q[0].data);
            chk("out_rank", out_rank, m_rank);
            chk("out_last", out_last, exp_q.size() == 1);
         end
         if (out_valid && out_ready && !abort)
            got_q.push_back({13'd0, out_int, out_data, out_rank, out_last});
         if (abort) begin
            m_ph = M_IDLE; m_cnt = 0; m_bubble = 0; m_gap = 0;
            exp_q.delete();
         end else begin
            case (m_ph)
               M_IDLE: if (start) begin
                  m_ph = M_COLLECT; m_cnt = 0; m_bubble = 0;
               end
               M_COLLECT: begin
                  if (in_valid && e_ir) begin
                     wrote    = model_insert(int'(in_int), int'(in_data));
                     m_bubble = wrote;
                     if (in_last) begin
                        model_build();
                        m_ph = M_EMIT; m_gap = 1; m_rank = 0;
                     end
                  end else begin
                     m_bubble = 0;
                  end
               end
               default: begin
                  if (m_gap) m_gap = 0;
                  else if (out_ready) begin
                     void'(exp_q.pop_front());
                     m_rank++;
                     if (exp_q.size() == 0) m_ph = M_IDLE;
                     else m_gap = 1;
                  end
               end
            endcase
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_window();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send_samples(input int n, input int a[8], input int d[8],
                               input bit mark_last, input bit gaps);
      int b;
      for (int s = 0; s < n; s++) begin
         if (gaps && $urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            tick();
         end
         in_valid = 1'b1;
         in_int   = INT_W'(a[s]);
         in_data  = DATA_W'(d[s]);
         in_last  = mark_last && (s == n - 1);
         b = 0;
         while (!in_ready && b < 20) begin tick(); b++; end
         if (!in_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL in_ready_timeout: actual=0 required=1 at %0t", $time);
            break;
         end
         tick();
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic drain(input int hold, input bit rnd);
      int held = 0;
      int b = 0;
      while (busy && b < 300) begin
         if (rnd) out_ready = 1'($urandom_range(0, 1));
         else if (out_valid && held < hold) begin out_ready = 1'b0; held++; end
         else out_ready = 1'b1;
         tick();
         b++;
      end
      if (busy) begin
         n_cmp++; n_bad++;
         $display("FAIL drain_timeout: actual busy=1 required busy=0 at %0t", $time);
      end
      out_ready = 1'b0;
   endtask

   task automatic wait_out_valid();
      int b = 0;
      while (!out_valid && b < 50) begin tick(); b++; end
      if (!out_valid) begin
         n_cmp++; n_bad++;
         $display("FAIL out_valid_timeout: actual=0 required=1 at %0t", $time);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int a[8];
      int d[8];
      int n;
      int ir_exp1[9];
      int ir_exp2[8];
      ir_exp1 = '{1, 0, 1, 0, 1, 0, 1, 0, 1};
      ir_exp2 = '{1, 0, 1, 0, 1, 0, 1, 1};

      // reset values
      #2;
      chk("rst_busy", busy, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_payload", {out_int, out_data, out_rank, out_last}, 0);
      #10 rst_n = 1'b1;
      tick();

      // basic window, also the written-every-sample throughput pattern
      got_q.delete(); ir_log.delete();
      start_window();
      ir_log_en = 1;
      send_samples(5, '{4, 9, 2, 7, 9, 0, 0, 0}, '{'h10, 'h11, 'h12, 'h13, 'h14, 0, 0, 0}, 1, 0);
      ir_log_en = 0;
      drain(0, 0);
      chk("basic_cnt", got_q.size(), 3);
      if (got_q.size() == 3) begin
         chk("basic_o0", got_q[0], pk(9, 'h14, 0, 0));
         chk("basic_o1", got_q[1], pk(9, 'h11, 1, 0));
         chk("basic_o2", got_q[2], pk(7, 'h13, 2, 1));
      end
      chk("thru_len", ir_log.size(), 9);
      if (ir_log.size() == 9)
         for (int i = 0; i < 9; i++) chk("thru_ir", ir_log[i], ir_exp1[i]);

      // ties and a dropped sample without bubble
      got_q.delete(); ir_log.delete();
      start_window();
      ir_log_en = 1;
      send_samples(5, '{5, 5, 5, 5, 6, 0, 0, 0}, '{'h20, 'h21, 'h22, 'h23, 'h24, 0, 0, 0}, 1, 0);
      ir_log_en = 0;
      drain(0, 0);
      chk("tie_cnt", got_q.size(), 3);
      if (got_q.size() == 3) begin
         chk("tie_o0", got_q[0], pk(6, 'h24, 0, 0));
         chk("tie_o1", got_q[1], pk(5, 'h21, 1, 0));
         chk("tie_o2", got_q[2], pk(5, 'h22, 2, 1));
      end
      chk("tie_ir_len", ir_log.size(), 8);
      if (ir_log.size() == 8)
         for (int i = 0; i < 8; i++) chk("tie_ir", ir_log[i], ir_exp2[i]);

      // short window
      got_q.delete();
      start_window();
      send_samples(1, '{0, 0, 0, 0, 0, 0, 0, 0}, '{'h3FF, 0, 0, 0, 0, 0, 0, 0}, 1, 0);
      drain(0, 0);
      chk("short_cnt", got_q.size(), 1);
      if (got_q.size() == 1) chk("short_o0", got_q[0], pk(0, 'h3FF, 0, 1));
      chk("short_busy", busy, 0);

      // backpressure with inputs offered during emit
      got_q.delete();
      start_window();
      send_samples(3, '{3, 12, 8, 0, 0, 0, 0, 0}, '{'h31, 'h32, 'h33, 0, 0, 0, 0, 0}, 1, 0);
      in_valid = 1'b1; in_int = 5'd31; in_data = 10'h2AA;
      drain(5, 0);
      in_valid = 1'b0;
      chk("bp_cnt", got_q.size(), 3);
      if (got_q.size() == 3) begin
         chk("bp_o0", got_q[0], pk(12, 'h32, 0, 0));
         chk("bp_o2", got_q[2], pk(3, 'h31, 2, 1));
      end

      // abort colliding with a handshake, then a fresh window
      got_q.delete();
      start_window();
      send_samples(3, '{1, 2, 3, 0, 0, 0, 0, 0}, '{'h1, 'h2, 'h3, 0, 0, 0, 0, 0}, 1, 0);
      wait_out_valid();
      abort = 1'b1; out_ready = 1'b1;
      tick();
      abort = 1'b0; out_ready = 1'b0;
      chk("abort_out_valid", out_valid, 0);
      chk("abort_busy", busy, 0);
      chk("abort_no_hs", got_q.size(), 0);
      start_window();
      send_samples(2, '{8, 3, 0, 0, 0, 0, 0, 0}, '{'h55, 'h66, 0, 0, 0, 0, 0, 0}, 1, 0);
      drain(0, 0);
      chk("post_abort_cnt", got_q.size(), 2);
      if (got_q.size() == 2) begin
         chk("post_abort_o0", got_q[0], pk(8, 'h55, 0, 0));
         chk("post_abort_o1", got_q[1], pk(3, 'h66, 1, 1));
      end

      // async reset mid-collect
      start_window();
      send_samples(2, '{7, 9, 0, 0, 0, 0, 0, 0}, '{'h7, 'h9, 0, 0, 0, 0, 0, 0}, 0, 0);
      chk("pre_rst_busy", busy, 1);
      #1 rst_n = 1'b0;
      #1;
      chk("arst_busy", busy, 0);
      chk("arst_in_ready", in_ready, 0);
      chk("arst_out_valid", out_valid, 0);
      chk("arst_payload", {out_int, out_data, out_rank, out_last}, 0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      tick();

      // random windows, some aborted mid-collect
      for (int w = 0; w < 40; w++) begin
         n = $urandom_range(1, 8);
         for (int j = 0; j < 8; j++) begin
            a[j] = (w % 2 == 1) ? $urandom_range(0, 3) : $urandom_range(0, 31);
            d[j] = $urandom_range(0, 1023);
         end
         start_window();
         if (w % 5 == 2) begin
            send_samples(n, a, d, 0, 1);
            abort = 1'b1;
            tick();
            abort = 1'b0;
            chk("rnd_abort_busy", busy, 0);
         end else begin
            send_samples(n, a, d, 1, 1);
            drain(0, 1);
         end
         if ($urandom_range(0, 1) == 1) tick();
      end

      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
